// File: rtl/ceespu_int_ctrl.sv
// Four-source interrupt controller: rising-edge capture into pending bits, fixed priority (0 highest),
// one-shot request/acknowledge toward decode. Define CEESPU_INT_MASK_EN for a writable enable mask.
module ceespu_int_ctrl (
    input  logic       I_clk,
    input  logic       I_rst,
    input  logic [3:0] I_irq,
    input  logic       I_int_ack,
    input  logic [3:0] I_clear,
    input  logic       I_mask_we,
    input  logic [3:0] I_mask_data,
    output logic       O_int,
    output logic [1:0] O_int_vector,
    output logic [3:0] O_pending,
    output logic [3:0] O_overflow,
    output logic [3:0] O_mask
);

    // Handshake: O_int/O_int_vector are held from REQ entry until the cycle I_int_ack is
    // sampled high (served) or I_clear of the latched source withdraws the request.
    typedef enum logic [1:0] {IDLE, REQ, HOLDOFF} state_t;

    state_t     state;
    logic [3:0] irq_q;
    logic [3:0] pending;
    logic [3:0] overflow;
    logic [3:0] mask;
    logic [3:0] edge_det;
    logic [3:0] ack_clr;
    logic [3:0] pend_nxt;
    logic [3:0] ovf_nxt;
    logic [3:0] req_bits;
    logic [1:0] prio_vec;

`ifdef CEESPU_INT_MASK_EN
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            mask <= 4'b1111;
        end else if (I_mask_we) begin
            mask <= I_mask_data;
        end
    end
`else
    logic unused_mask_in;
    assign unused_mask_in = ^{I_mask_we, I_mask_data};
    assign mask = 4'b1111;
`endif

    assign edge_det = I_irq & ~irq_q;
    // O_int_vector equals the latched vector whenever the state is REQ.
    assign ack_clr  = (state == REQ && I_int_ack) ? (4'b0001 << O_int_vector) : 4'b0000;
    assign pend_nxt = edge_det | (pending & ~(I_clear | ack_clr));
    // A clear coinciding with an edge leaves the overflow flag untouched.
    assign ovf_nxt  = (overflow & ~(I_clear & ~edge_det)) | (edge_det & pending & ~I_clear);
    assign req_bits = pending & mask;

    always_comb begin
        prio_vec = 2'd0;
        if (req_bits[0])      prio_vec = 2'd0;
        else if (req_bits[1]) prio_vec = 2'd1;
        else if (req_bits[2]) prio_vec = 2'd2;
        else if (req_bits[3]) prio_vec = 2'd3;
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            irq_q    <= I_irq;
            pending  <= 4'b0000;
            overflow <= 4'b0000;
        end else begin
            irq_q    <= I_irq;
            pending  <= pend_nxt;
            overflow <= ovf_nxt;
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state        <= IDLE;
            O_int        <= 1'b0;
            O_int_vector <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_bits) begin
                        state        <= REQ;
                        O_int        <= 1'b1;
                        O_int_vector <= prio_vec;
                    end
                end
                REQ: begin
                    if (I_int_ack) begin
                        state        <= HOLDOFF;
                        O_int        <= 1'b0;
                        O_int_vector <= 2'd0;
                    end else if (I_clear[O_int_vector]) begin
                        state        <= IDLE;
                        O_int        <= 1'b0;
                        O_int_vector <= 2'd0;
                    end
                end
                HOLDOFF: begin
                    state        <= IDLE;
                    O_int        <= 1'b0;
                    O_int_vector <= 2'd0;
                end
                default: begin
                    state        <= IDLE;
                    O_int        <= 1'b0;
                    O_int_vector <= 2'd0;
                end
            endcase
        end
    end

    assign O_pending  = pending;
    assign O_overflow = overflow;
    assign O_mask     = mask;

endmodule
